// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA raster constants (640x480@60 defaults) and sync-bus type, used by the
// timing generator and the drawing stage so both read one source of timing truth.
package vga_timing_gen_pkg;

  localparam int VGA_H_VISIBLE_AREA = 640;
  localparam int VGA_H_FRONT_PORCH  = 16;
  localparam int VGA_H_SYNC_PULSE   = 96;
  localparam int VGA_H_BACK_PORCH   = 48;

  localparam int VGA_V_VISIBLE_AREA = 480;
  localparam int VGA_V_FRONT_PORCH  = 10;
  localparam int VGA_V_SYNC_PULSE   = 2;
  localparam int VGA_V_BACK_PORCH   = 33;

  localparam logic VGA_H_SYNC_POL = 1'b0;
  localparam logic VGA_V_SYNC_POL = 1'b0;
  localparam int   VGA_SYNC_DELAY = 2;

  typedef struct packed {
    logic vsync;
    logic hsync;
  } vga_sync_t;

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Async-reset shift register that delays the sync pair to match RGB pipeline latency.
// DEPTH=0 passes the input straight through.
module sync_delay_line #(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster timing source: position counters, strobes and delayed sync.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_VISIBLE_AREA = VGA_H_VISIBLE_AREA,
  parameter int   H_FRONT_PORCH  = VGA_H_FRONT_PORCH,
  parameter int   H_SYNC_PULSE   = VGA_H_SYNC_PULSE,
  parameter int   H_BACK_PORCH   = VGA_H_BACK_PORCH,
  parameter int   V_VISIBLE_AREA = VGA_V_VISIBLE_AREA,
  parameter int   V_FRONT_PORCH  = VGA_V_FRONT_PORCH,
  parameter int   V_SYNC_PULSE   = VGA_V_SYNC_PULSE,
  parameter int   V_BACK_PORCH   = VGA_V_BACK_PORCH,
  parameter logic H_SYNC_POL     = VGA_H_SYNC_POL,
  parameter logic V_SYNC_POL     = VGA_V_SYNC_POL,
  parameter int   SYNC_DELAY     = VGA_SYNC_DELAY,
  localparam int  H_WHOLE_LINE   = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int  V_WHOLE_LINE   = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int  H_ADDR_WIDTH   = $clog2(H_WHOLE_LINE),
  localparam int  V_ADDR_WIDTH   = $clog2(V_WHOLE_LINE)
) (
  input  logic                    vga_pix_clk,
  input  logic                    rst,
  output logic [H_ADDR_WIDTH-1:0] sx,
  output logic [V_ADDR_WIDTH-1:0] sy,
  output logic                    display_enabled,
  output logic                    line_stb,
  output logic                    frame_stb,
  output logic                    hsync,
  output logic                    vsync
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_count
`endif
);

  localparam logic [H_ADDR_WIDTH-1:0] H_LAST       = H_ADDR_WIDTH'(H_WHOLE_LINE - 1);
  localparam logic [H_ADDR_WIDTH-1:0] H_VIS        = H_ADDR_WIDTH'(H_VISIBLE_AREA);
  localparam logic [H_ADDR_WIDTH-1:0] H_SYNC_START = H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [H_ADDR_WIDTH-1:0] H_SYNC_END   = H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [V_ADDR_WIDTH-1:0] V_LAST       = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);
  localparam logic [V_ADDR_WIDTH-1:0] V_VIS        = V_ADDR_WIDTH'(V_VISIBLE_AREA);
  localparam logic [V_ADDR_WIDTH-1:0] V_SYNC_START = V_ADDR_WIDTH'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [V_ADDR_WIDTH-1:0] V_SYNC_END   = V_ADDR_WIDTH'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

  localparam vga_sync_t SYNC_IDLE = '{vsync: ~V_SYNC_POL, hsync: ~H_SYNC_POL};

  logic [H_ADDR_WIDTH-1:0] sx_next;
  logic [V_ADDR_WIDTH-1:0] sy_next;
  logic                    h_active;
  logic                    v_active;
  vga_sync_t               raw_sync;
  vga_sync_t               sync_out;

  // Every registered output is decoded from the next position, so they all describe
  // the pixel that sx/sy will hold after this edge.
  always_comb begin
    sx_next = sx + H_ADDR_WIDTH'(1);
    sy_next = sy;
    if (sx == H_LAST) begin
      sx_next = '0;
      sy_next = (sy == V_LAST) ? '0 : sy + V_ADDR_WIDTH'(1);
    end
    h_active = (sx_next >= H_SYNC_START) && (sx_next < H_SYNC_END);
    v_active = (sy_next >= V_SYNC_START) && (sy_next < V_SYNC_END);
  end

  always_ff @(posedge vga_pix_clk or posedge rst) begin
    if (rst) begin
      sx              <= H_LAST;
      sy              <= V_LAST;
      display_enabled <= 1'b0;
      line_stb        <= 1'b0;
      frame_stb       <= 1'b0;
      raw_sync        <= SYNC_IDLE;
    end else begin
      sx              <= sx_next;
      sy              <= sy_next;
      display_enabled <= (sx_next < H_VIS) && (sy_next < V_VIS);
      line_stb        <= (sx_next == '0);
      frame_stb       <= (sx_next == '0) && (sy_next == V_VIS);
      raw_sync.hsync  <= h_active ? H_SYNC_POL : ~H_SYNC_POL;
      raw_sync.vsync  <= v_active ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge vga_pix_clk or posedge rst) begin
    if (rst) begin
      frame_count <= 16'd0;
    end else if ((sx_next == '0) && (sy_next == V_VIS)) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

  sync_delay_line #(
    .WIDTH     (2),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk (vga_pix_clk),
    .rst (rst),
    .d   (raw_sync),
    .q   (sync_out)
  );

  assign hsync = sync_out.hsync;
  assign vsync = sync_out.vsync;

endmodule
